la_capture_controller: RTL and testbench

Parametrised capture sequencer for the logic analyzer core. It drives the sample-memory write port as a circular FIFO and handles three trigger modes: single-shot with programmable pre-trigger depth, immediate, and incremental. It sits between the register file (mode, start/stop, trigger position, status) and the trigger block / sample BRAM. Host readout begins at read_pointer once state is CAPTURED.

---
 rtl/la_pkg.sv | 22 ++
 rtl/la_fifo_pointers.sv | 47 ++++
 rtl/la_capture_controller.sv | 134 +++++++++++++
 tb/tb_la_capture_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared encodings for the logic-analyzer capture path: FSM states and trigger modes.
package la_pkg;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } la_state_t;

    localparam logic [1:0] SINGLE_SHOT   = 2'd0;
    localparam logic [1:0] INCREMENTAL   = 2'd1;
    localparam logic [1:0] IMMEDIATE     = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // The reserved encoding behaves exactly like single-shot.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_RESERVED) ? SINGLE_SHOT : m;
    endfunction

endpackage

// File: rtl/la_fifo_pointers.sv
// Circular-buffer bookkeeping for the sample BRAM: read/write pointers and fill count.
module la_fifo_pointers #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [ADDR_WIDTH-1:0] write_pointer,
    output logic [ADDR_WIDTH:0]   fill
);

    localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DEPTH);

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full  = (fill == FILL_MAX);
    assign empty = (fill == '0);

    // A simultaneous push/pop is a pass-through slide, so it is allowed even at
    // the saturation limits (needed for a zero-length pre-trigger window).
    assign do_push = push && (!full  || pop);
    assign do_pop  = pop  && (!empty || push);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            read_pointer  <= '0;
            write_pointer <= '0;
            fill          <= '0;
        end else begin
            if (do_push) write_pointer <= write_pointer + 1'b1;
            if (do_pop)  read_pointer  <= read_pointer + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/la_capture_controller.sv
// Capture sequencer: arms on a start edge, fills the pre-trigger window, waits for
// the trigger and streams samples into the BRAM until DEPTH samples are held.
module la_capture_controller
    import la_pkg::*;
#(
    parameter  int DEPTH      = 1024,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request_start,
    input  logic                  request_stop,
    input  logic [1:0]            trigger_mode,
    input  logic [ADDR_WIDTH-1:0] trigger_loc,
    input  logic                  trig,
    output logic [2:0]            state,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [ADDR_WIDTH-1:0] write_pointer,
    output logic [ADDR_WIDTH:0]   fill,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_we
);

    localparam logic [ADDR_WIDTH:0] FILL_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    la_state_t             state_q;
    la_state_t             state_n;
    logic                  start_q;
    logic                  stop_q;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] loc_q;

    logic       start_edge;
    logic       stop_edge;
    logic       arm;
    logic       clear;
    logic       push;
    logic       pop;
    logic       we;
    logic [1:0] mode_in;

    assign start_edge = request_start && !start_q;
    assign stop_edge  = request_stop  && !stop_q;
    assign mode_in    = norm_mode(trigger_mode);

    // trigger_loc is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            loc_q   <= '0;
            // Track the live levels so a request held high across reset
            // is not mistaken for a fresh rising edge afterwards.
            start_q <= request_start;
            stop_q  <= request_stop;
        end else begin
            state_q <= state_n;
            start_q <= request_start;
            stop_q  <= request_stop;
            if (arm) begin
                mode_q <= mode_in;
                loc_q  <= trigger_loc;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        arm     = 1'b0;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        we      = 1'b0;
        if (stop_edge) begin
            // Abort without writing; pointers stay put so partial data is readable.
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE, CAPTURED: begin
                    if (start_edge) begin
                        arm   = 1'b1;
                        clear = 1'b1;
                        if (mode_in == IMMEDIATE || mode_in == INCREMENTAL)
                            state_n = CAPTURING;
                        else if (trigger_loc == '0)
                            state_n = IN_POSITION;
                        else
                            state_n = MOVE_TO_POSITION;
                    end
                end
                MOVE_TO_POSITION: begin
                    we   = 1'b1;
                    push = 1'b1;
                    if (fill + 1'b1 == {1'b0, loc_q})
                        state_n = IN_POSITION;
                end
                IN_POSITION: begin
                    we   = 1'b1;
                    push = 1'b1;
                    if (trig)
                        state_n = (fill == FILL_LAST) ? CAPTURED : CAPTURING;
                    else
                        pop = 1'b1;
                end
                CAPTURING: begin
                    we   = (mode_q == INCREMENTAL) ? trig : 1'b1;
                    push = we;
                    if (we && fill == FILL_LAST)
                        state_n = CAPTURED;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    la_fifo_pointers #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptrs (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .push          (push),
        .pop           (pop),
        .read_pointer  (read_pointer),
        .write_pointer (write_pointer),
        .fill          (fill)
    );

    assign state     = state_q;
    assign bram_we   = we;
    assign bram_addr = write_pointer;

endmodule

// File: tb/tb_la_capture_controller.sv
// Directed bench for la_capture_controller at DEPTH=8; expectations go through a queue
// when stimulus is applied and are popped against DUT outputs.
module tb_la_capture_controller;
    import la_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          request_start;
    logic          request_stop;
    logic [1:0]    trigger_mode;
    logic [AW-1:0] trigger_loc;
    logic          trig;
    logic [2:0]    state;
    logic [AW-1:0] read_pointer;
    logic [AW-1:0] write_pointer;
    logic [AW:0]   fill;
    logic [AW-1:0] bram_addr;
    logic          bram_we;

    int    checks   = 0;
    int    failures = 0;
    int    exp_q[$];
    string tag_q[$];
    int    wcnt;
    int    pulses;

    la_capture_controller #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .request_start (request_start),
        .request_stop  (request_stop),
        .trigger_mode  (trigger_mode),
        .trigger_loc   (trigger_loc),
        .trig          (trig),
        .state         (state),
        .read_pointer  (read_pointer),
        .write_pointer (write_pointer),
        .fill          (fill),
        .bram_addr     (bram_addr),
        .bram_we       (bram_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_val(input string t, input int v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string t;
        int    e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d required=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === 32'(e)) else begin
                failures++;
                $error("FAIL %s observed=%0d required=%0d", t, obs, e);
            end
        end
    endtask

    task automatic arm(input logic [1:0] m, input logic [AW-1:0] l);
        request_start = 1'b0;
        tick();
        trigger_mode  = m;
        trigger_loc   = l;
        request_start = 1'b1;
    endtask

    initial begin
        rst = 1'b1; request_start = 1'b0; request_stop = 1'b0;
        trigger_mode = 2'd0; trigger_loc = '0; trig = 1'b0;
        repeat (2) tick();
        expect_val("rst_state", 0); chk(state);
        expect_val("rst_rp", 0);    chk(read_pointer);
        expect_val("rst_wp", 0);    chk(write_pointer);
        expect_val("rst_fill", 0);  chk(fill);
        expect_val("rst_we", 0);    chk(bram_we);
        rst = 1'b0;
        tick();

        // Single-shot, 3 pre-trigger samples, trigger 10 cycles after start.
        arm(SINGLE_SHOT, 3'd3);
        wcnt = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            trig = (i == 10);
            settle();
            expect_val("ss3_state", (i <= 3) ? 1 : (i <= 10) ? 2 : (i <= 14) ? 3 : 4);
            chk(state);
            if (i == 10) begin
                expect_val("ss3_trig_addr", 1); chk(bram_addr);
            end
            if (bram_we) wcnt++;
        end
        expect_val("ss3_fill", 8);        chk(fill);
        expect_val("ss3_rp", 6);          chk(read_pointer);
        expect_val("ss3_wp", 6);          chk(write_pointer);
        expect_val("ss3_trig_at_loc", 1); chk((read_pointer + 3'd3) % 8);
        expect_val("ss3_we_done", 0);     chk(bram_we);
        expect_val("ss3_writes", 14);     chk(wcnt);

        // Single-shot with an empty pre-trigger window; loc change after arming is ignored.
        arm(SINGLE_SHOT, 3'd0);
        wcnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            trigger_loc = 3'd5;
            trig = (i == 2);
            settle();
            expect_val("ss0_state", (i <= 2) ? 2 : (i <= 9) ? 3 : 4);
            chk(state);
            if (i == 1) begin
                expect_val("ss0_wp_cleared", 0); chk(write_pointer);
            end
            if (i == 2) begin
                expect_val("ss0_trig_addr", 1); chk(bram_addr);
            end
            if (i >= 2 && bram_we) wcnt++;
        end
        expect_val("ss0_fill", 8);    chk(fill);
        expect_val("ss0_rp", 1);      chk(read_pointer);
        expect_val("ss0_writes", 8);  chk(wcnt);

        // Immediate mode with trig held low.
        arm(IMMEDIATE, 3'd4);
        wcnt = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            settle();
            expect_val("imm_state", (i <= 8) ? 3 : 4);
            chk(state);
            if (bram_we) wcnt++;
        end
        expect_val("imm_writes", 8); chk(wcnt);
        expect_val("imm_rp", 0);     chk(read_pointer);
        expect_val("imm_wp", 0);     chk(write_pointer);
        expect_val("imm_fill", 8);   chk(fill);

        // Incremental: writes only on trigger cycles.
        arm(INCREMENTAL, 3'd0);
        wcnt = 0; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            trig = (i == 2 || i == 5 || i == 9 || i == 13 ||
                    i == 20 || i == 27 || i == 33 || i == 38);
            settle();
            expect_val("inc_state", (pulses < 8) ? 3 : 4);
            chk(state);
            expect_val("inc_we", (pulses < 8) ? int'(trig) : 0);
            chk(bram_we);
            if (trig) pulses++;
            if (bram_we) wcnt++;
        end
        trig = 1'b0;
        expect_val("inc_writes", 8); chk(wcnt);
        expect_val("inc_fill", 8);   chk(fill);

        // Stop while in position with a full pre-trigger window.
        arm(SINGLE_SHOT, 3'd3);
        repeat (4) tick();
        expect_val("stop_pre_state", 2); chk(state);
        expect_val("stop_pre_fill", 3);  chk(fill);
        request_stop = 1'b1;
        tick();
        expect_val("stop_state", 0); chk(state);
        expect_val("stop_we", 0);    chk(bram_we);
        expect_val("stop_fill", 3);  chk(fill);
        request_stop = 1'b0; request_start = 1'b0;
        tick();
        request_start = 1'b1; request_stop = 1'b1;
        tick();
        expect_val("both_state", 0); chk(state);
        expect_val("both_fill", 3);  chk(fill);

        // Reset in the middle of a capture, start held high throughout.
        request_stop = 1'b0;
        arm(IMMEDIATE, 3'd0);
        repeat (6) tick();
        expect_val("rstcap_state", 3); chk(state);
        expect_val("rstcap_fill", 5);  chk(fill);
        rst = 1'b1;
        tick();
        expect_val("rstcap_post_state", 0); chk(state);
        expect_val("rstcap_post_rp", 0);    chk(read_pointer);
        expect_val("rstcap_post_wp", 0);    chk(write_pointer);
        expect_val("rstcap_post_fill", 0);  chk(fill);
        expect_val("rstcap_post_we", 0);    chk(bram_we);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_val("no_rearm_state", 0); chk(state);
            expect_val("no_rearm_we", 0);    chk(bram_we);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
